trace_sram_reader: RTL

Sequencer that reads a memory-address trace out of the 32x1024 trace SRAM and streams it word by word to the cache-hierarchy model over a valid/ready handshake. It is the consumer end of the trace SRAM path. The host fills the SRAM through the logic-analyzer port. This block then owns the SRAM port for the duration of a run and returns it to the host when idle. It sits in `user_project_wrapper` between the LA-driven SRAM controls, the `sram_32_1024_sky130A` instance and the cache model.

---
 rtl/trace_sram_reader_if.sv | 11 +
 rtl/trace_sram_reader.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/trace_sram_reader_if.sv
// Trace stream handshake between the SRAM reader (producer) and the cache model (consumer).
interface trace_sram_reader_if #(
  parameter int DATA_W = 32
) ();
  logic              valid;
  logic [DATA_W-1:0] data;
  logic              rdy;

  modport master (output valid, output data, input rdy);
  modport slave  (input valid, input data, output rdy);
endinterface

// File: rtl/trace_sram_reader.sv
// Streams a trace out of the trace SRAM through a 2-entry buffer, owning the SRAM port while
// busy and handing it back to the host in IDLE/DONE.
module trace_sram_reader #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 32
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                start,
  input  logic [ADDR_W:0]     trace_len,
  input  logic                host_csb,
  input  logic                host_web,
  input  logic [ADDR_W-1:0]   host_addr,
  input  logic [DATA_W-1:0]   host_din,
  output logic                csb0,
  output logic                web0,
  output logic [ADDR_W-1:0]   addr0,
  output logic [DATA_W-1:0]   din0,
  input  logic [DATA_W-1:0]   dout0,
  trace_sram_reader_if.master trace,
  output logic                busy,
  output logic                done,
  output logic [ADDR_W:0]     sent_count
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_e;

  localparam logic [ADDR_W:0] LEN_MAX = {1'b1, {ADDR_W{1'b0}}};

  state_e            state_q, state_d;
  logic [ADDR_W:0]   len_q, len_d;
  logic [ADDR_W:0]   issued_q, issued_d;
  logic [ADDR_W:0]   sent_q, sent_d;
  logic [ADDR_W-1:0] ptr_q, ptr_d;
  logic              inflight_q, inflight_d;
  logic [1:0]        count_q, count_d;
  logic              rd_idx_q, rd_idx_d;
  logic              wr_idx_q, wr_idx_d;
  logic [DATA_W-1:0] buf_q [2];

  logic [ADDR_W:0]   len_clamped_s;
  logic              pop_s;
  logic              push_s;
  logic              issue_s;
  logic [2:0]        occ_s;
  logic [2:0]        lim_s;

  // Handshake, capture and issue decisions for the current cycle
  always_comb begin
    len_clamped_s = trace_len;
    if (trace_len > LEN_MAX) begin
      len_clamped_s = LEN_MAX;
    end else begin
      len_clamped_s = trace_len;
    end
    pop_s  = (count_q != 2'd0) && trace.rdy;
    push_s = inflight_q;
    // A slot freed by this cycle's pop may be claimed by this cycle's read.
    occ_s  = {1'b0, count_q} + {2'b00, inflight_q};
    lim_s  = 3'd2 + {2'b00, pop_s};
    if ((state_q == S_RUN) && (issued_q < len_q) && (occ_s < lim_s)) begin
      issue_s = 1'b1;
    end else begin
      issue_s = 1'b0;
    end
  end

  // Next-state and datapath updates
  always_comb begin
    state_d    = state_q;
    len_d      = len_q;
    issued_d   = issued_q + {{ADDR_W{1'b0}}, issue_s};
    ptr_d      = ptr_q + {{(ADDR_W-1){1'b0}}, issue_s};
    inflight_d = issue_s;
    count_d    = count_q + {1'b0, push_s} - {1'b0, pop_s};
    rd_idx_d   = rd_idx_q ^ pop_s;
    wr_idx_d   = wr_idx_q ^ push_s;
    if (pop_s && (sent_q < len_q)) begin
      sent_d = sent_q + {{ADDR_W{1'b0}}, 1'b1};
    end else begin
      sent_d = sent_q;
    end
    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          len_d    = len_clamped_s;
          issued_d = '0;
          ptr_d    = '0;
          sent_d   = '0;
          if (len_clamped_s != '0) begin
            state_d = S_RUN;
          end else begin
            state_d = S_DONE;
          end
        end else begin
          state_d = state_q;
        end
      end
      S_RUN: begin
        if (issued_d == len_q) begin
          state_d = S_DRAIN;
        end else begin
          state_d = S_RUN;
        end
      end
      S_DRAIN: begin
        if (count_d == 2'd0) begin
          state_d = S_DONE;
        end else begin
          state_d = S_DRAIN;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State, counters and buffer storage
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q    <= S_IDLE;
      len_q      <= '0;
      issued_q   <= '0;
      sent_q     <= '0;
      ptr_q      <= '0;
      inflight_q <= 1'b0;
      count_q    <= 2'd0;
      rd_idx_q   <= 1'b0;
      wr_idx_q   <= 1'b0;
      buf_q[0]   <= '0;
      buf_q[1]   <= '0;
    end else begin
      state_q    <= state_d;
      len_q      <= len_d;
      issued_q   <= issued_d;
      sent_q     <= sent_d;
      ptr_q      <= ptr_d;
      inflight_q <= inflight_d;
      count_q    <= count_d;
      rd_idx_q   <= rd_idx_d;
      wr_idx_q   <= wr_idx_d;
      if (push_s) begin
        buf_q[wr_idx_q] <= dout0;
      end
    end
  end

  // SRAM port ownership: host when idle/done, reader otherwise
  always_comb begin
    if (busy) begin
      csb0  = ~issue_s;
      web0  = 1'b1;
      addr0 = ptr_q;
      din0  = '0;
    end else begin
      csb0  = host_csb;
      web0  = host_web;
      addr0 = host_addr;
      din0  = host_din;
    end
  end

  assign trace.valid = (count_q != 2'd0);
  assign trace.data  = buf_q[rd_idx_q];
  assign busy        = (state_q == S_RUN) || (state_q == S_DRAIN);
  assign done        = (state_q == S_DONE);
  assign sent_count  = sent_q;

endmodule
